// File: rtl/register_bank.sv
// General-purpose register file: one write port from writeback, two registered
// read ports with write-first bypass, and a one-cycle rd_valid flag.
module register_bank #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                             clk_in,
  input  logic                             RST,
  input  logic                             wr_en,
  input  logic        [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0]     wr_data,
  input  logic                             rd_en,
  input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic signed [DATA_WIDTH-1:0]     rd_data_a,
  output logic signed [DATA_WIDTH-1:0]     rd_data_b,
  output logic                             rd_valid
);

  localparam int NREGS = 2 ** REG_ADDR_WIDTH;

  logic signed [DATA_WIDTH-1:0] r_regs [NREGS];
  logic signed [DATA_WIDTH-1:0] w_next_a;
  logic signed [DATA_WIDTH-1:0] w_next_b;

  // Read-port selection: a same-cycle write to the addressed register wins.
  always_comb begin
    w_next_a = r_regs[rd_addr_a];
    w_next_b = r_regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_a)) begin
      w_next_a = wr_data;
    end else begin
      w_next_a = r_regs[rd_addr_a];
    end
    if (wr_en && (wr_addr == rd_addr_b)) begin
      w_next_b = wr_data;
    end else begin
      w_next_b = r_regs[rd_addr_b];
    end
  end

  // Register array: cleared on reset, one write per cycle otherwise.
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end else begin
      r_regs[wr_addr] <= r_regs[wr_addr];
    end
  end

  // Read output registers: load on rd_en, hold otherwise; reset drops a pending read.
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      rd_data_a <= {DATA_WIDTH{1'b0}};
      rd_data_b <= {DATA_WIDTH{1'b0}};
      rd_valid  <= 1'b0;
    end else if (rd_en) begin
      rd_data_a <= w_next_a;
      rd_data_b <= w_next_b;
      rd_valid  <= 1'b1;
    end else begin
      rd_data_a <= rd_data_a;
      rd_data_b <= rd_data_b;
      rd_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a write-first array model compared every
// cycle, plus literal expectations for each scenario.
module tb_register_bank;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NREGS = 2 ** AW;

  logic          clk_in = 1'b0;
  logic          RST = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          rd_valid;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  register_bank #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk_in   (clk_in),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .rd_valid (rd_valid)
  );

  always #5 clk_in = ~clk_in;

  // Model: the array as it looks after this cycle's write; reads see that view.
  logic [DW-1:0] m_mem  [NREGS];
  logic [DW-1:0] m_post [NREGS];
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic          m_v = 1'b0;

  always_comb begin
    m_post = m_mem;
    if (RST && wr_en) m_post[wr_addr] = wr_data;
  end

  always @(posedge clk_in) begin
    if (!RST) begin
      for (int k = 0; k < NREGS; k++) m_mem[k] <= '0;
      m_a <= '0;
      m_b <= '0;
      m_v <= 1'b0;
    end else begin
      m_mem <= m_post;
      m_v   <= rd_en;
      if (rd_en) begin
        m_a <= m_post[rd_addr_a];
        m_b <= m_post[rd_addr_b];
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("model_rd_data_a", rd_data_a, m_a);
      check("model_rd_data_b", rd_data_b, m_b);
      check("model_rd_valid", {15'd0, rd_valid}, {15'd0, m_v});
    end
  end

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic re, input int ra, input int rb);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_en = re; rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
  endtask

  initial begin
    // Initial reset
    RST = 1'b0;
    drive(1'b0, 0, 16'h0000, 1'b0, 0, 0);
    cycle();
    RST = 1'b1;
    cmp_en = 1'b1;
    check("reset_valid", {15'd0, rd_valid}, 16'd0);
    check("reset_data_a", rd_data_a, 16'h0000);

    // 1: reset wipes r3 and drops the read issued in the reset cycle
    drive(1'b1, 3, 16'h1234, 1'b0, 0, 0);
    cycle();
    drive(1'b0, 0, 16'h0000, 1'b1, 3, 3);
    cycle();
    check("t1_pre_read", rd_data_a, 16'h1234);
    RST = 1'b0;
    drive(1'b1, 3, 16'h4321, 1'b1, 3, 3);
    cycle();
    check("t1_rst_valid", {15'd0, rd_valid}, 16'd0);
    check("t1_rst_data_b", rd_data_b, 16'h0000);
    RST = 1'b1;
    drive(1'b0, 0, 16'h0000, 1'b1, 3, 0);
    cycle();
    check("t1_after_rst_a", rd_data_a, 16'h0000);
    check("t1_after_rst_valid", {15'd0, rd_valid}, 16'd1);

    // 2: basic write then read
    drive(1'b1, 5, 16'hFFF9, 1'b0, 0, 0);
    cycle();
    drive(1'b0, 0, 16'h0000, 1'b1, 5, 0);
    cycle();
    check("t2_a", rd_data_a, 16'hFFF9);
    check("t2_b", rd_data_b, 16'h0000);
    check("t2_valid", {15'd0, rd_valid}, 16'd1);

    // 3: same-cycle bypass on both ports
    drive(1'b1, 7, 16'h0055, 1'b0, 0, 0);
    cycle();
    drive(1'b1, 7, 16'h00AA, 1'b1, 7, 7);
    cycle();
    check("t3_bypass_a", rd_data_a, 16'h00AA);
    check("t3_bypass_b", rd_data_b, 16'h00AA);

    // 4: disabled write neither stores nor bypasses
    drive(1'b0, 2, 16'h7FFF, 1'b1, 2, 2);
    cycle();
    check("t4_nobypass_a", rd_data_a, 16'h0000);
    drive(1'b0, 2, 16'h7FFF, 1'b1, 2, 5);
    cycle();
    check("t4_nowrite_a", rd_data_a, 16'h0000);
    check("t4_r5_b", rd_data_b, 16'hFFF9);

    // 5: outputs hold while rd_en is low
    drive(1'b1, 1, 16'h0011, 1'b0, 0, 0);
    cycle();
    drive(1'b0, 0, 16'h0000, 1'b1, 1, 7);
    cycle();
    check("t5_read_a", rd_data_a, 16'h0011);
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1, 16'h0022, 1'b0, 1, 1);
      cycle();
      check("t5_hold_a", rd_data_a, 16'h0011);
      check("t5_hold_b", rd_data_b, 16'h00AA);
      check("t5_hold_valid", {15'd0, rd_valid}, 16'd0);
    end
    drive(1'b0, 0, 16'h0000, 1'b1, 1, 1);
    cycle();
    check("t5_new_a", rd_data_a, 16'h0022);

    // 6: full sweep, r(i) = i*0x0101, read as (i, NREGS-1-i)
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b1, i, DW'(i * 257), 1'b0, 0, 0);
      cycle();
    end
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, 0, 16'h0000, 1'b1, i, NREGS - 1 - i);
      cycle();
      check("t6_sweep_a", rd_data_a, DW'(i * 257));
      check("t6_sweep_b", rd_data_b, DW'((NREGS - 1 - i) * 257));
    end
    check("t6_r15_literal", rd_data_a, 16'h0F0F);
    check("t6_r0_literal", rd_data_b, 16'h0000);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
